// File: rtl/stump_mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-ported memory with
// a fixed number of wait cycles per access.
module stump_mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic              busy,
  output logic              grant_d
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT);

  state_t              state_q, state_d;
  logic [2:0]          wait_q, wait_d;
  logic                own_d_q, own_d_d;
  logic                last_d_q, last_d_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                pick_d;

  // Data port has priority, except right after a completed data grant.
  assign pick_d = d_req & (~i_req | ~last_d_q);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    own_d_d   = own_d_q;
    last_d_d  = last_d_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          own_d_d = pick_d;
          addr_d  = pick_d ? d_addr : i_addr;
          wdata_d = pick_d ? d_wdata : '0;
          wen_d   = pick_d & d_wen;
          wait_d  = WAIT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_q != 3'd0) begin
          wait_d = wait_q - 3'd1;
        end else begin
          if (!wen_q) begin
            if (own_d_q) d_rdata_d = mem_rdata;
            else         i_rdata_d = mem_rdata;
          end
          state_d = ACK;
        end
      end
      ACK: begin
        last_d_d = own_d_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wait_q    <= 3'd0;
      own_d_q   <= 1'b0;
      last_d_q  <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      own_d_q   <= own_d_d;
      last_d_q  <= last_d_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Strobes and acks decode straight from registered state, so reset clears them at once.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ren   = (state_q == ACCESS) & ~wen_q;
  assign mem_wen   = (state_q == ACCESS) & wen_q;
  assign i_ack     = (state_q == ACK) & ~own_d_q;
  assign d_ack     = (state_q == ACK) & own_d_q;
  assign busy      = (state_q != IDLE);
  assign grant_d   = busy & own_d_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Bench for stump_mem_arbiter: three instances (WAIT = 2, 0, 7) with an ack
// scoreboard checked by a forked monitor.
module tb_stump_mem_arbiter;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        rst_n   [3];
  logic        i_req   [3];
  logic [15:0] i_addr  [3];
  logic [15:0] i_rdata [3];
  logic        i_ack   [3];
  logic        d_req   [3];
  logic        d_wen   [3];
  logic [15:0] d_addr  [3];
  logic [15:0] d_wdata [3];
  logic [15:0] d_rdata [3];
  logic        d_ack   [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic        mem_ren [3];
  logic        mem_wen [3];
  logic        busy    [3];
  logic        grant_d [3];
  logic [15:0] key     [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    stump_mem_arbiter #(
      .DATA_W(16), .ADDR_W(16), .WAIT((g == 0) ? 2 : ((g == 1) ? 0 : 7))
    ) u_dut (
      .clk(clk), .rst(rst_n[g]),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_ack(i_ack[g]),
      .d_req(d_req[g]), .d_wen(d_wen[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .mem_ren(mem_ren[g]), .mem_wen(mem_wen[g]), .busy(busy[g]), .grant_d(grant_d[g])
    );
    // Memory model: read data is the address XOR a per-test key.
    assign mem_rdata[g] = mem_addr[g] ^ key[g];
  end

  typedef struct {
    int          inst;
    bit          is_d;
    logic [15:0] rdata;
    bit          chk_rd;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (i_ack[k] || d_ack[k]) begin
          if (sb.size() == 0) begin
            chk($sformatf("unexpected_ack_inst%0d", k), {i_ack[k], d_ack[k]}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("ack_inst", k, e.inst);
            chk("ack_port_d", {i_ack[k], d_ack[k]}, e.is_d ? 32'd1 : 32'd2);
            chk("ack_cycle", cyc, e.cyc);
            if (e.chk_rd)
              chk("ack_rdata", e.is_d ? d_rdata[k] : i_rdata[k], e.rdata);
          end
        end
      end
    end
  endtask

  task automatic chk_zero(input int k, input string nm);
    chk({nm, "_busy"},    busy[k], 0);
    chk({nm, "_grant_d"}, grant_d[k], 0);
    chk({nm, "_acks"},    {i_ack[k], d_ack[k]}, 0);
    chk({nm, "_strobes"}, {mem_ren[k], mem_wen[k]}, 0);
    chk({nm, "_mem_addr"},  mem_addr[k], 0);
    chk({nm, "_mem_wdata"}, mem_wdata[k], 0);
    chk({nm, "_i_rdata"}, i_rdata[k], 0);
    chk({nm, "_d_rdata"}, d_rdata[k], 0);
  endtask

  // One transaction on instance k; req dropped at offset drop_at (or in the IDLE after ACK).
  task automatic xfer(input int k, input int w, input bit is_d, input bit wen,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] exp_rd, input int drop_at);
    int n;
    if (is_d) begin
      d_req[k] = 1'b1; d_wen[k] = wen; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
    end
    n = cyc;
    sb.push_back('{k, is_d, exp_rd, 1'b1, n + w + 2});
    for (int t = 1; t <= w + 3; t++) begin
      step();
      if (t == drop_at || t == w + 3) begin
        if (is_d) d_req[k] = 1'b0;
        else      i_req[k] = 1'b0;
      end
      if (t <= w + 1) begin
        chk("acc_ren_wen", {mem_ren[k], mem_wen[k]}, wen ? 32'd1 : 32'd2);
        chk("acc_addr", mem_addr[k], addr);
        chk("acc_grant_d", grant_d[k], is_d);
        if (wen) chk("acc_wdata", mem_wdata[k], wdata);
      end else if (t == w + 2) begin
        chk("ack_strobes_low", {mem_ren[k], mem_wen[k]}, 0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0;
      d_wen[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; key[k] = '0;
    end
    fork
      monitor();
    join_none
    step();
    step();
    for (int k = 0; k < 3; k++) chk_zero(k, $sformatf("por%0d", k));
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

    // WAIT=2 single instruction read
    key[0] = 16'hBEFF;
    xfer(0, 2, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0);
    chk("rd_d_rdata_untouched", d_rdata[0], 16'h0000);

    // Abandoned data read: req dropped in the first ACCESS cycle
    key[0] = 16'h0000;
    xfer(0, 2, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0020, 1);
    chk("abandon_i_rdata_kept", i_rdata[0], 16'hBEEF);
    repeat (4) step();

    // WAIT=0: read to preload d_rdata, then a write that must not disturb it
    key[1] = 16'h5A1A;
    xfer(1, 0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 0);
    key[1] = 16'h0F0F;
    xfer(1, 0, 1'b1, 1'b1, 16'h0200, 16'h1234, 16'h5A5A, 0);
    chk("wr_d_rdata_kept", d_rdata[1], 16'h5A5A);
    chk("wr_i_rdata_kept", i_rdata[1], 16'h0000);

    // WAIT=7 read
    key[2] = 16'h1243;
    xfer(2, 7, 1'b0, 1'b0, 16'h0077, 16'h0000, 16'h1234, 0);

    // Contention from reset: D, I, D, I
    rst_n[0] = 1'b0;
    #1;
    chk_zero(0, "cont_rst");
    key[0] = 16'hAB00;
    i_req[0] = 1'b1; i_addr[0] = 16'h0100;
    d_req[0] = 1'b1; d_wen[0] = 1'b0; d_addr[0] = 16'h0300;
    step();
    rst_n[0] = 1'b1;
    begin
      int n;
      n = cyc;
      sb.push_back('{0, 1'b1, 16'hA800, 1'b1, n + 4});
      sb.push_back('{0, 1'b0, 16'hAA00, 1'b1, n + 9});
      sb.push_back('{0, 1'b1, 16'hA800, 1'b1, n + 14});
      sb.push_back('{0, 1'b0, 16'hAA00, 1'b1, n + 19});
      for (int t = 1; t <= 20; t++) begin
        step();
        if (t == 1 || t == 6 || t == 11 || t == 16)
          chk($sformatf("cont_grant_d_t%0d", t), grant_d[0], (t == 1 || t == 11) ? 1 : 0);
      end
      i_req[0] = 1'b0; d_req[0] = 1'b0;
    end
    repeat (2) step();

    // Reset in the second ACCESS cycle, then a fresh request right after release
    key[0] = 16'h0000;
    i_req[0] = 1'b1; i_addr[0] = 16'h0030;
    step();
    chk("mid_busy_before", busy[0], 1);
    step();
    rst_n[0] = 1'b0;
    #1;
    chk_zero(0, "mid_rst");
    i_req[0] = 1'b0;
    repeat (3) step();
    rst_n[0] = 1'b1;
    xfer(0, 2, 1'b1, 1'b0, 16'h0044, 16'h0000, 16'h0044, 0);
    chk("mid_i_rdata_cleared", i_rdata[0], 16'h0000);

    repeat (5) step();
    chk("pending_acks", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
